fp32_mul_sequencer: RTL and testbench
=====================================

# fp32_mul_sequencer

Multi-cycle controller for the 32-bit IEEE-754 single-precision multiply path. Accepts an operand pair over a valid/ready handshake and forms the result sign through the XOR sign-calculation unit. It then sequences the exponent add, a 24-iteration shift-add mantissa multiply, normalization, round-to-nearest-even and packing, and returns the result with exception flags over a second valid/ready handshake. It is the single owner of the multiply datapath; one operation is in flight at a time.

## Interface
- QNAN, 32'h7FC0_0000, canonical quiet NaN returned for invalid operations
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept; equals (state==IDLE)
- a, b  in  32  operands, IEEE-754 single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  packed product
- ovf, unf, nv  out  1 each  overflow, underflow (flush), invalid
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, UNPACK, MUL, NORM, ROUND, DONE.
- IDLE: when in_valid && in_ready, register a and b, then go to UNPACK.
- UNPACK:
  - sign = a[31]^b[31].
  - Exponent 0 means zero; denormals are treated as zero.
  - Special cases, all going directly to DONE:
    - any NaN, or inf×zero -> QNAN, nv=1.
    - inf×(nonzero or inf) -> {sign,8'hFF,23'h0}.
    - zero×finite -> {sign,31'h0}.
  - Otherwise: exp = ea+eb−127 in a 10-bit signed register; mantissas {1,frac} (24 bits); clear the 48-bit product accumulator and the 5-bit iteration counter; go to MUL.
- MUL:
  - Each cycle: if multiplier bit[counter] is set, add the multiplicand shifted left by counter to the accumulator.
  - Counter 0..23; leave after counter==23.
- NORM:
  - If P[47]: mantissa = P[47:24], guard = P[23], sticky = |P[22:0], exp += 1.
  - Else: mantissa = P[46:23], guard = P[22], sticky = |P[21:0].
- ROUND:
  - RNE: increment when guard && (sticky || mantissa[0]).
  - Carry out of 24 bits -> mantissa = 24'h800000, exp += 1.
  - exp ≥ 255 -> {sign,8'hFF,0}, ovf=1.
  - exp ≤ 0 -> {sign,31'h0}, unf=1.
  - Else pack {sign, exp[7:0], mantissa[22:0]}.
- DONE:
  - out_valid=1; result and flags held stable.
  - When out_ready is high, go to IDLE.
  - No new operand is accepted in the same cycle; in_ready rises the next cycle.
- Flags are cleared when a new operand is accepted.

## Timing
- Reset (rst high at an edge):
  - State -> IDLE.
  - out_valid=0, result=0, ovf=unf=nv=0, busy=0.
  - Counter and accumulator cleared.
  - in_ready=1 after the edge.
  - in_valid is ignored while rst is high.
- Reset mid-operation (any state): the operation is abandoned and no out_valid is produced.
- Latency, counted from the accepting edge (edge 0):
  - Normal operands: UNPACK at edge 1, MUL at edges 2–25, NORM at 26, ROUND at 27, out_valid high after edge 28.
  - Special cases: out_valid high after edge 2.
- Backpressure: out_valid, result and flags stay constant until the edge at which out_ready is sampled high. Minimum spacing between accepts is 30 cycles for normal operands.
- out_ready is don't-care when out_valid=0.
- in_valid while busy: ignored; the source holds its data.

## Test plan
- 3F800000 × 40000000 -> result 40000000, flags 0, out_valid first high 28 cycles after accept.
- BFC00000 × 40200000 -> C0700000 (−3.75), flags 0.
- 3F800001 × 3F800001 -> 3F800002 (RNE rounds down); 7F800000 × 00000000 -> 7FC00000, nv=1, latency 2.
- 7F000000 × 40000000 -> 7F800000, ovf=1; 00800000 × 00800000 -> 00000000, unf=1; 00000001 × 3F800000 -> 00000000 (denormal as zero).
- Hold out_ready=0 for 10 cycles after out_valid -> result and flags stable, in_ready=0; pulse in_valid with new data during this window -> ignored.
- Assert rst during MUL (edge 10) -> next cycle in_ready=1, busy=0, out_valid=0. A fresh 3F800000 × 3F800000 then returns 3F800000 with normal latency.

Source files
------------

// File: rtl/fp32_mul_sequencer.sv
// fp32_mul_sequencer
//   Multi-cycle IEEE-754 single-precision multiplier controller. One
//   operation is in flight at a time: operands are captured in IDLE, then
//   the block steps through UNPACK, MUL (24 shift-add iterations), NORM,
//   ROUND and DONE, where the result is presented until consumed.
//   Denormal inputs are treated as zero; underflowing results are flushed.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The source holds its data/valid until that edge; the sink may
//   raise or lower ready freely while valid is low.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept operands (state == IDLE)
//   a, b       IEEE-754 single operands
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     packed product
//   ovf/unf/nv overflow, underflow (flushed to zero), invalid
//   busy       high in every state except IDLE
//   dbg_state  current FSM state encoding

module fp32_mul_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        nv,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MUL    = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic               sign;
  logic signed [9:0]  exp_q;
  logic [23:0]        mcand;
  logic [23:0]        mplier;
  logic [47:0]        acc;
  logic [4:0]         cnt;
  logic [23:0]        mant;
  logic               guard;
  logic               sticky;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Operand classification of the captured pair
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    fa     = a_q[22:0];
    fb     = b_q[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    b_nan  = (eb == 8'hFF) && (fb != 23'h0);
  end

  // Biased exponent sum, kept signed so underflow shows as <= 0
  logic signed [9:0] exp_sum;
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  // Shift-add partial product for the current iteration
  logic [47:0] addend;
  assign addend = mplier[cnt] ? ({24'd0, mcand} << cnt) : 48'd0;

  // Round-to-nearest-even; bit 24 is the carry out of the mantissa
  logic              rnd_inc;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_rnd;
  assign rnd_inc  = guard && (sticky || mant[0]);
  assign mant_rnd = {1'b0, mant} + {24'd0, rnd_inc};
  assign exp_rnd  = exp_q + (mant_rnd[24] ? 10'sd1 : 10'sd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      sign      <= 1'b0;
      exp_q     <= 10'sd0;
      mcand     <= 24'd0;
      mplier    <= 24'd0;
      acc       <= 48'd0;
      cnt       <= 5'd0;
      mant      <= 24'd0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      result    <= 32'd0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      nv        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            nv    <= 1'b0;
            state <= UNPACK;
          end
        end

        UNPACK: begin
          sign <= a_q[31] ^ b_q[31];
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            result <= QNAN;
            nv     <= 1'b1;
            state  <= DONE;
          end else if (a_inf || b_inf) begin
            result <= {a_q[31] ^ b_q[31], 8'hFF, 23'h0};
            state  <= DONE;
          end else if (a_zero || b_zero) begin
            result <= {a_q[31] ^ b_q[31], 31'h0};
            state  <= DONE;
          end else begin
            exp_q  <= exp_sum;
            mcand  <= {1'b1, fa};
            mplier <= {1'b1, fb};
            acc    <= 48'd0;
            cnt    <= 5'd0;
            state  <= MUL;
          end
        end

        MUL: begin
          acc <= acc + addend;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            state <= NORM;
          end
        end

        NORM: begin
          if (acc[47]) begin
            mant   <= acc[47:24];
            guard  <= acc[23];
            sticky <= |acc[22:0];
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant   <= acc[46:23];
            guard  <= acc[22];
            sticky <= |acc[21:0];
          end
          state <= ROUND;
        end

        ROUND: begin
          if (exp_rnd >= 10'sd255) begin
            result <= {sign, 8'hFF, 23'h0};
            ovf    <= 1'b1;
          end else if (exp_rnd <= 10'sd0) begin
            result <= {sign, 31'h0};
            unf    <= 1'b1;
          end else begin
            // On carry-out the mantissa is 1.0, so the fraction is zero
            result <= {sign, exp_rnd[7:0], mant_rnd[24] ? 23'h0 : mant_rnd[22:0]};
          end
          state <= DONE;
        end

        DONE: begin
          // out_valid rises one cycle after entering DONE and drops on the
          // consuming edge; in_ready follows only after the return to IDLE.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_sequencer.sv
module tb_fp32_mul_sequencer;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        nv;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {ovf, unf, nv, result}
  logic [34:0] exp_q[$];

  fp32_mul_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .nv        (nv),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    logic   s;
    int     ex, ey, e, sh;
    longint fx, fy, p, q, rem, half;
    bit     x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    x_nan  = (ex == 255) && (fx != 0);
    y_nan  = (ey == 255) && (fy != 0);
    x_inf  = (ex == 255) && (fx == 0);
    y_inf  = (ey == 255) && (fy == 0);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      return {3'b001, QNAN};
    if (x_inf || y_inf)
      return {3'b000, s, 8'hFF, 23'h0};
    if (x_zero || y_zero)
      return {3'b000, s, 31'h0};
    // Exact integer product of the significands, then round to 24 bits
    p = ((64'd1 << 23) + fx) * ((64'd1 << 23) + fy);
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {3'b100, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'h00;
      1: begin e = 8'hFF; f = 23'h0; end
      2: begin e = 8'hFF; f = (f == 23'h0) ? 23'h1 : f; end
      3, 4, 5: e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Called a little after a rising edge. Sends one operand pair, measures
  // latency, optionally stalls the output for `hold` cycles (pulsing
  // in_valid with junk when `pulse` is set), then consumes the result.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input int hold, input bit pulse);
    logic [34:0] e;
    int lat;
    int w;
    int exp_lat;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    exp_q.push_back(model(op_a, op_b));
    exp_lat  = is_special(op_a, op_b) ? 2 : 28;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    check("result", 64'(result), 64'(e[31:0]));
    check("flags", 64'({ovf, unf, nv}), 64'(e[34:32]));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (pulse) begin
        a        = $urandom;
        b        = $urandom;
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_result", 64'(result), 64'(e[31:0]));
      check("hold_flags", 64'({ovf, unf, nv}), 64'(e[34:32]));
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_consume", 64'(out_valid), 64'd0);
    check("in_ready_after_consume", 64'(in_ready), 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b1;   // must be ignored during reset
    out_ready = 1'b0;
    a         = 32'h3F80_0000;
    b         = 32'h3F80_0000;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'({ovf, unf, nv}), 64'd0);

    // Directed vectors
    run_op(32'h3F80_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'hBFC0_0000, 32'h4020_0000, 0, 1'b0);
    run_op(32'h3F80_0001, 32'h3F80_0001, 0, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 0, 1'b0);
    run_op(32'h7F00_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'h0080_0000, 32'h0080_0000, 0, 1'b0);
    run_op(32'h0000_0001, 32'h3F80_0000, 0, 1'b0);
    run_op(32'hFF80_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'h7FC0_1234, 32'h3F80_0000, 0, 1'b0);
    // Backpressure with junk in_valid pulses
    run_op(32'h4040_0000, 32'h4040_0000, 10, 1'b1);

    // Reset in the middle of MUL (edge 10 after accept)
    a        = 32'h3F80_0000;
    b        = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    seen_valid = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_output", 64'(seen_valid), 64'd0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 0, 1'b0);

    // Randomized operations against the model
    for (int i = 0; i < 30; i++) begin
      run_op(rand_op(), rand_op(), $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
